ntt_bfu_addsub: RTL and testbench
=================================

// Module: ntt_bfu_addsub
// PURPOSE
// - Cooley-Tukey butterfly back-end sitting directly downstream of the modular multiplier (`MO_MUL).
// - Takes the multiplier product t = b*w and the matching top operand a; emits a+t mod Q and a-t mod Q.
// - Re-times a and a valid tag so they meet the product after the multiplier latency; flags last pair of a block.
// PARAMETERS
// - MUL_LAT    default MUL_STAGE_CNT  cycles from multiplier input to result (must equal `MO_MUL latency)
// - PAIRS      default 128            butterflies per block; out_last asserted on pair PAIRS-1
// PORTS
// - clk        in   1           single clock, rising edge
// - rst        in   1           asynchronous, active-low reset (rst==0 resets immediately)
// - in_valid   in   1           operands issued to multiplier this cycle
// - a_in       in   DATA_WIDTH  top operand, issued same cycle as multiplier inputs, range [0,Q)
// - mul_in     in   DATA_WIDTH  multiplier result, range [0,2Q), valid MUL_LAT cycles after issue
// - out_valid  out  1           sum/diff valid
// - out_sum    out  DATA_WIDTH  (a+t) mod Q, range [0,Q)
// - out_diff   out  DATA_WIDTH  (a-t) mod Q, range [0,Q)
// - out_last   out  1           qualifies last pair (index PAIRS-1) of block
// BEHAVIOUR
// - No backpressure: multiplier has no enable, block accepts every cycle, never stalls.
// - Delay line: a_in and in_valid shifted MUL_LAT stages; stage MUL_LAT pairs a with mul_in.
// - S1 (reg): t = (mul_in >= Q) ? mul_in-Q : mul_in; a and valid forwarded.
// - S2 (reg): s = a+t, out_sum = (s>=Q) ? s-Q : s; d = a-t (DATA_WIDTH+1 signed), out_diff = (d<0) ? d+Q : d.
// - Latency in_valid -> out_valid = MUL_LAT+2 cycles exactly; throughput 1 pair/cycle.
// - Adds in DATA_WIDTH+1 bits; no overflow for Q < 2^(DATA_WIDTH-1).
// - Pair counter cnt (clog2(PAIRS) bits): increments on each out_valid; out_last = out_valid && cnt==PAIRS-1;
//   wraps to 0 after PAIRS-1; bubbles (out_valid=0) hold cnt.
// - Reset: out_valid, out_last, out_sum, out_diff, cnt, all valid-delay bits = 0; data-delay regs need not reset.
// - Reset mid-block: in-flight pairs discarded, no out_valid until MUL_LAT+2 after next in_valid, cnt restarts at 0.
// - Delay-line data registers must not gate on valid; only valid bits qualify outputs.
// - Boundary: a==t -> diff 0; a=0,t=Q-1 -> sum Q-1, diff 1; mul_in==Q -> treated as 0.
// CONFIGURATION
// - `BFU_HALF_EN defined: S2 also halves both outputs mod Q (INTT last-layer scaling):
//   x/2 = x[0] ? (x+Q)>>1 : x>>1, computed in DATA_WIDTH+1 bits; latency unchanged (MUL_LAT+2).
// - `BFU_HALF_EN undefined: plain sum/diff as above, no halving logic generated.
// STRUCTURE
// - ntt_pkg: Q, DATA_WIDTH, MUL_STAGE_CNT (existing); add typedef coef_t = logic [DATA_WIDTH-1:0]
//   and function mod_half(coef_t) shared with INTT stages.
// - One sub-module: ntt_mod_addsub (combinational a,t -> sum,diff, optional halving); this module owns
//   delay line, S1/S2 registers and pair counter.
// TESTING (Q=3329, MUL_LAT=MUL_STAGE_CNT, PAIRS=4 unless noted; bench drives mul_in from golden model at issue+MUL_LAT)
// - a=5, t=3 -> out_sum=8, out_diff=2, out_valid exactly MUL_LAT+2 cycles after in_valid.
// - a=3000, t=1000 -> sum=671, diff=2000; a=0, t=1 -> sum=1, diff=3328; mul_in=3330 -> t=1 used.
// - 8 back-to-back valid pairs -> 8 consecutive out_valid, out_last high on 4th and 8th only.
// - 3 valids, 2-cycle in_valid gap, 1 valid -> out_last on 4th output; gap bubbles do not advance cnt.
// - rst low for 1 cycle with 3 pairs in flight -> outputs 0 immediately, none emitted, next block's out_last on its 4th pair.
// - `BFU_HALF_EN: a=5,t=3 -> sum 4, diff 1; a=0,t=1 -> sum 1665, diff 1664; a=3000,t=1000 -> sum 2000, diff 1000.
// - Random sweep all a,t in [0,Q) (mul_in in [0,2Q)) vs. golden (a±t) mod Q, zero mismatches.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT constants, the coefficient type and the modular-halving
// helper used by the butterfly back-end and the INTT stages.
package ntt_pkg;

   localparam int Q             = 3329;
   localparam int DATA_WIDTH    = 13;
   localparam int MUL_STAGE_CNT = 3;

   typedef logic [DATA_WIDTH-1:0] coef_t;

   localparam coef_t Q_C = coef_t'(Q);

   // x/2 mod Q for x in [0,Q): odd values borrow one Q so the shift is exact.
   function automatic coef_t mod_half(input coef_t x);
      logic [DATA_WIDTH:0] w;
      w = x[0] ? ({1'b0, x} + {1'b0, Q_C}) : {1'b0, x};
      return w[DATA_WIDTH:1];
   endfunction

endpackage

// File: rtl/ntt_mod_addsub.sv
// ntt_mod_addsub: combinational modular add/sub of two reduced operands.
// Optional feature macro: BFU_HALF_EN (both results additionally halved mod Q).
module ntt_mod_addsub
   import ntt_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] t_i,
   output logic [DATA_WIDTH-1:0] sum_o,
   output logic [DATA_WIDTH-1:0] diff_o
);

   localparam logic [DATA_WIDTH:0] Q_W = {1'b0, Q_C};

   logic [DATA_WIDTH:0] s_raw;
   logic [DATA_WIDTH:0] d_raw;
   logic [DATA_WIDTH:0] s_red;
   logic [DATA_WIDTH:0] d_red;

   // After reduction both results lie in [0,Q), so their MSBs are always zero.
   logic unused_red_msb;
   assign unused_red_msb = s_red[DATA_WIDTH] ^ d_red[DATA_WIDTH];

   // One extra bit of headroom: sum reaches 2Q-2, difference goes negative.
   // NOTE: every always_comb output gets a value on every path (here by plain
   // straight-line assignment), otherwise synthesis infers a latch.
   always_comb begin
      s_raw = {1'b0, a_i} + {1'b0, t_i};
      s_red = (s_raw >= Q_W) ? (s_raw - Q_W) : s_raw;
      d_raw = {1'b0, a_i} - {1'b0, t_i};
      d_red = d_raw[DATA_WIDTH] ? (d_raw + Q_W) : d_raw;
`ifdef BFU_HALF_EN
      sum_o  = mod_half(s_red[DATA_WIDTH-1:0]);
      diff_o = mod_half(d_red[DATA_WIDTH-1:0]);
`else
      sum_o  = s_red[DATA_WIDTH-1:0];
      diff_o = d_red[DATA_WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/ntt_bfu_addsub.sv
// ntt_bfu_addsub: Cooley-Tukey butterfly back-end behind the modular multiplier.
// Re-times a/valid over the multiplier latency, reduces the product (S1), forms
// (a+t) mod Q and (a-t) mod Q (S2) and flags the last pair of each block.
// Optional feature macro: BFU_HALF_EN (INTT last-layer halving, same latency).
module ntt_bfu_addsub
   import ntt_pkg::*;
#(
   parameter int MUL_LAT = MUL_STAGE_CNT,
   parameter int PAIRS   = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] mul_in,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_sum,
   output logic [DATA_WIDTH-1:0] out_diff,
   output logic                  out_last
);

   localparam int                CNT_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PAIRS - 1);

   logic [MUL_LAT-1:0]    vld_dly_q;
   logic [DATA_WIDTH-1:0] a_dly_q [MUL_LAT];

   logic                  v1_q;
   logic [DATA_WIDTH-1:0] a1_q;
   logic [DATA_WIDTH-1:0] t_q;
   logic [DATA_WIDTH-1:0] t_d;

   logic [DATA_WIDTH-1:0] sum_d;
   logic [DATA_WIDTH-1:0] diff_d;

   logic                  out_valid_q;
   logic                  out_last_q;
   logic [DATA_WIDTH-1:0] out_sum_q;
   logic [DATA_WIDTH-1:0] out_diff_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;

   // Product arrives in [0,2Q); one conditional subtract brings it into [0,Q).
   always_comb begin
      t_d = (mul_in >= Q_C) ? (mul_in - Q_C) : mul_in;
   end

   // Wrap the pair counter at PAIRS-1 (PAIRS need not be a power of two).
   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
   end

   // Valid tag delay line plus S1 valid; reset discards everything in flight.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the clock edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_dly_q <= '0;
         v1_q      <= 1'b0;
      end else begin
         vld_dly_q[0] <= in_valid;
         for (int i = 1; i < MUL_LAT; i++) begin
            vld_dly_q[i] <= vld_dly_q[i-1];
         end
         v1_q <= vld_dly_q[MUL_LAT-1];
      end
   end

   // Data side of the delay line and S1: shifts every cycle, never gated by valid.
   // NOTE: these data registers have no reset; the valid tags alone decide
   // whether their contents mean anything, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      a_dly_q[0] <= a_in;
      for (int i = 1; i < MUL_LAT; i++) begin
         a_dly_q[i] <= a_dly_q[i-1];
      end
      a1_q <= a_dly_q[MUL_LAT-1];
      t_q  <= t_d;
   end

   ntt_mod_addsub u_mod_addsub (
      .a_i    (a1_q),
      .t_i    (t_q),
      .sum_o  (sum_d),
      .diff_o (diff_d)
   );

   // S2 output register and pair counter; bubbles leave the counter untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_sum_q   <= '0;
         out_diff_q  <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= v1_q;
         out_last_q  <= v1_q && (cnt_q == CNT_MAX);
         out_sum_q   <= sum_d;
         out_diff_q  <= diff_d;
         if (v1_q) begin
            cnt_q <= cnt_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_sum   = out_sum_q;
   assign out_diff  = out_diff_q;

endmodule

// File: tb/tb_ntt_bfu_addsub.sv
// tb_ntt_bfu_addsub: self-checking bench for ntt_bfu_addsub (PAIRS=4).
// Expected outputs come from plain modular arithmetic and an issue counter.
module tb_ntt_bfu_addsub;
   import ntt_pkg::*;

   localparam int L     = MUL_STAGE_CNT;
   localparam int PAIRS = 4;
   localparam int N     = 2048;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] a_in;
   logic [DATA_WIDTH-1:0] mul_in;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_sum;
   logic [DATA_WIDTH-1:0] out_diff;
   logic                  out_last;

   ntt_bfu_addsub #(
      .MUL_LAT (L),
      .PAIRS   (PAIRS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a_in      (a_in),
      .mul_in    (mul_in),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_diff  (out_diff),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int issued = 0;

   // Expected output per cycle, and the product the multiplier delivers per cycle.
   bit exp_v    [N];
   int exp_sum  [N];
   int exp_diff [N];
   bit exp_last [N];
   bit sched_v  [N];
   int sched_m  [N];

   function automatic int halve(input int x);
      return (x % 2 != 0) ? (x + Q) / 2 : x / 2;
   endfunction

   function automatic int gold_sum(input int a, input int m);
      int r;
      r = (a + (m % Q)) % Q;
`ifdef BFU_HALF_EN
      r = halve(r);
`endif
      return r;
   endfunction

   function automatic int gold_diff(input int a, input int m);
      int r;
      r = (a - (m % Q) + Q) % Q;
`ifdef BFU_HALF_EN
      r = halve(r);
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, want);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         exp_v[i]   = 1'b0;
         sched_v[i] = 1'b0;
      end
      issued = 0;
   endtask

   // One clock: check this cycle's outputs, then drive this cycle's inputs.
   task automatic tick(input bit v, input int a, input int m);
      int k;
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(exp_v[cyc]));
      if (exp_v[cyc]) begin
         check("out_sum",  32'(out_sum),  exp_sum[cyc]);
         check("out_diff", 32'(out_diff), exp_diff[cyc]);
         check("out_last", 32'(out_last), 32'(exp_last[cyc]));
      end
      in_valid = v;
      a_in     = v ? DATA_WIDTH'(a) : DATA_WIDTH'($urandom_range(0, Q - 1));
      mul_in   = sched_v[cyc] ? DATA_WIDTH'(sched_m[cyc])
                              : DATA_WIDTH'($urandom_range(0, 2 * Q - 1));
      if (v) begin
         sched_v[cyc + L] = 1'b1;
         sched_m[cyc + L] = m;
         k = cyc + L + 2;
         exp_v[k]    = 1'b1;
         exp_sum[k]  = gold_sum(a, m);
         exp_diff[k] = gold_diff(a, m);
         exp_last[k] = ((issued % PAIRS) == PAIRS - 1);
         issued++;
      end
      cyc++;
      if (cyc + L + 3 >= N) begin
         $display("FAIL tb_cycle_budget cycle=%0d limit=%0d", cyc, N);
         $fatal(1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 0);
   endtask

   task automatic tick_rand();
      tick(1'b1, int'($urandom_range(0, Q - 1)), int'($urandom_range(0, 2 * Q - 1)));
   endtask

   // Assert reset for one cycle mid-stream; outputs must clear immediately.
   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_last",  32'(out_last),  0);
      check("rst_out_sum",   32'(out_sum),   0);
      check("rst_out_diff",  32'(out_diff),  0);
      clear_model();
      cyc++;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      a_in     = '0;
      mul_in   = '0;
      clear_model();
      #2;
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_out_last",  32'(out_last),  0);
      check("reset_out_sum",   32'(out_sum),   0);
      check("reset_out_diff",  32'(out_diff),  0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // Single pair: exact latency and basic values.
      tick(1'b1, 5, 3);
      idle(L + 4);

      // Directed boundary pairs, back to back (completes the first block of 4 twice).
      tick(1'b1, 3000, 1000);
      tick(1'b1, 0, 1);
      tick(1'b1, 7, 3330);
      tick(1'b1, 100, 100);
      tick(1'b1, 0, 3328);
      tick(1'b1, 9, 3329);
      tick(1'b1, 3328, 6657);
      idle(L + 4);

      // Eight back-to-back pairs: out_last on the 4th and 8th.
      for (int i = 0; i < 8; i++) tick_rand();
      idle(L + 4);

      // Three pairs, two-cycle gap, one pair: out_last on the 4th output.
      for (int i = 0; i < 3; i++) tick_rand();
      idle(2);
      tick_rand();
      idle(L + 4);

      // Reset with pairs in flight and one visible on the outputs.
      for (int i = 0; i < 7; i++) tick_rand();
      pulse_reset();
      for (int i = 0; i < 4; i++) tick_rand();
      idle(L + 4);

      // Random sweep with random bubbles.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) tick_rand();
         else tick(1'b0, 0, 0);
      end
      idle(L + 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
